// File: rtl/hex_display_pkg.sv
// Shared constants for the hex display scanner: segment glyphs, the nibble decoder,
// and the legal parameter ranges.
package hex_display_pkg;

    localparam int MAX_DIGITS       = 8;
    localparam int MIN_REFRESH_DIV  = 2;
    localparam int MIN_BLINK_FRAMES = 1;

    // Segment order is {g,f,e,d,c,b,a}; a 0 bit lights the segment.
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_HEX_0 = 7'h40;
    localparam logic [6:0] SEG_HEX_1 = 7'h79;
    localparam logic [6:0] SEG_HEX_2 = 7'h24;
    localparam logic [6:0] SEG_HEX_3 = 7'h30;
    localparam logic [6:0] SEG_HEX_4 = 7'h19;
    localparam logic [6:0] SEG_HEX_5 = 7'h12;
    localparam logic [6:0] SEG_HEX_6 = 7'h02;
    localparam logic [6:0] SEG_HEX_7 = 7'h78;
    localparam logic [6:0] SEG_HEX_8 = 7'h00;
    localparam logic [6:0] SEG_HEX_9 = 7'h10;
    localparam logic [6:0] SEG_HEX_A = 7'h08;
    localparam logic [6:0] SEG_HEX_B = 7'h03;
    localparam logic [6:0] SEG_HEX_C = 7'h46;
    localparam logic [6:0] SEG_HEX_D = 7'h21;
    localparam logic [6:0] SEG_HEX_E = 7'h06;
    localparam logic [6:0] SEG_HEX_F = 7'h0E;

    // Counter widths never drop to zero, so a single-digit or single-frame build still elaborates.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic bit params_ok(input int num_digits, input int refresh_div,
                                     input int blank_cycles, input int blink_frames);
        return (num_digits >= 1) && (num_digits <= MAX_DIGITS) &&
               (refresh_div >= MIN_REFRESH_DIV) &&
               (blank_cycles >= 0) && (blank_cycles < refresh_div) &&
               (blink_frames >= MIN_BLINK_FRAMES);
    endfunction

    function automatic logic [6:0] hex_to_seg_f(input logic [3:0] nibble);
        logic [6:0] glyph;
        case (nibble)
            4'h0:    glyph = SEG_HEX_0;
            4'h1:    glyph = SEG_HEX_1;
            4'h2:    glyph = SEG_HEX_2;
            4'h3:    glyph = SEG_HEX_3;
            4'h4:    glyph = SEG_HEX_4;
            4'h5:    glyph = SEG_HEX_5;
            4'h6:    glyph = SEG_HEX_6;
            4'h7:    glyph = SEG_HEX_7;
            4'h8:    glyph = SEG_HEX_8;
            4'h9:    glyph = SEG_HEX_9;
            4'hA:    glyph = SEG_HEX_A;
            4'hB:    glyph = SEG_HEX_B;
            4'hC:    glyph = SEG_HEX_C;
            4'hD:    glyph = SEG_HEX_D;
            4'hE:    glyph = SEG_HEX_E;
            default: glyph = SEG_HEX_F;
        endcase
        return glyph;
    endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational nibble to active-low 7-segment glyph decoder.
module hex_to_seg
    import hex_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = hex_to_seg_f(nibble);
    end

endmodule

// File: rtl/hex_display_mux.sv
// Time-multiplexed common-anode 7-segment driver with frame-synchronous value update,
// per-digit enable/blink, leading-zero blanking and an anti-ghosting guard interval.
module hex_display_mux
    import hex_display_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 65536,
    parameter int BLANK_CYCLES = 16,
    parameter int BLINK_FRAMES = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [NUM_DIGITS-1:0]   blink,
    input  logic                    lz_blank,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    dp,
    output logic                    frame_sync
);

    localparam int PRESC_W = clog2_min1(REFRESH_DIV);
    localparam int IDX_W   = clog2_min1(NUM_DIGITS);
    localparam int BLINK_W = clog2_min1(BLINK_FRAMES);
    localparam int VAL_W   = 4 * NUM_DIGITS;

    if (!params_ok(NUM_DIGITS, REFRESH_DIV, BLANK_CYCLES, BLINK_FRAMES)) begin : g_param_check
        $error("hex_display_mux: illegal NUM_DIGITS/REFRESH_DIV/BLANK_CYCLES/BLINK_FRAMES");
    end

    logic [PRESC_W-1:0]    presc_q, presc_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [BLINK_W-1:0]    blink_cnt_q, blink_cnt_d;
    logic                  blink_phase_q, blink_phase_d;
    logic [VAL_W-1:0]      stage_val_q, stage_val_d;
    logic [NUM_DIGITS-1:0] stage_dp_q, stage_dp_d;
    logic                  pending_q, pending_d;
    logic [VAL_W-1:0]      shadow_val_q, shadow_val_d;
    logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  dp_q, dp_d;
    logic                  frame_sync_q, frame_sync_d;

    logic                  slot_end;
    logic                  frame_end;
    logic                  in_guard;
    logic [NUM_DIGITS-1:0] lz_zero;
    logic [NUM_DIGITS-1:0] dark;
    logic [3:0]            cur_nibble;
    logic [6:0]            cur_glyph;

    always_comb begin
        slot_end  = (presc_q == PRESC_W'(REFRESH_DIV - 1));
        frame_end = slot_end && (idx_q == IDX_W'(NUM_DIGITS - 1));
        presc_d   = slot_end ? '0 : presc_q + 1'b1;
        idx_d     = idx_q;
        if (slot_end) begin
            idx_d = frame_end ? '0 : idx_q + 1'b1;
        end
    end

    always_comb begin
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (frame_end) begin
            if (blink_cnt_q == BLINK_W'(BLINK_FRAMES - 1)) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    // Staging absorbs loads at any time; the shadow only moves at the frame boundary so a
    // scan never mixes digits from two different values. A load on the boundary cycle wins.
    always_comb begin
        stage_val_d  = stage_val_q;
        stage_dp_d   = stage_dp_q;
        pending_d    = pending_q;
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        if (load) begin
            stage_val_d = value;
            stage_dp_d  = dp_in;
            pending_d   = 1'b1;
        end
        if (frame_end && (pending_q || load)) begin
            shadow_val_d = load ? value : stage_val_q;
            shadow_dp_d  = load ? dp_in : stage_dp_q;
            pending_d    = 1'b0;
        end
    end

    // lz_zero[i] is set when every shadow nibble from the top digit down to i is zero.
    always_comb begin
        logic run_zero;
        run_zero = 1'b1;
        lz_zero  = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run_zero   = run_zero && (shadow_val_q[4*i +: 4] == 4'h0);
            lz_zero[i] = run_zero;
        end
    end

    always_comb begin
        dark = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            dark[i] = !digit_en[i]
                   || (blink[i] && blink_phase_q)
                   || (lz_blank && lz_zero[i] && (i != 0));
        end
    end

    always_comb begin
        cur_nibble = shadow_val_q[4*idx_q +: 4];
    end

    hex_to_seg u_hex_to_seg (
        .nibble (cur_nibble),
        .seg    (cur_glyph)
    );

    // Everything is decided from this cycle's state and lands on the pins one cycle later.
    always_comb begin
        in_guard     = (presc_q < PRESC_W'(BLANK_CYCLES));
        seg_d        = SEG_BLANK;
        an_d         = '1;
        dp_d         = 1'b1;
        frame_sync_d = frame_end;
        if (!in_guard && !dark[idx_q]) begin
            an_d[idx_q] = 1'b0;
            seg_d       = cur_glyph;
            dp_d        = ~shadow_dp_q[idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q       <= '0;
            idx_q         <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            stage_val_q   <= '0;
            stage_dp_q    <= '0;
            pending_q     <= 1'b0;
            shadow_val_q  <= '0;
            shadow_dp_q   <= '0;
            seg_q         <= SEG_BLANK;
            an_q          <= '1;
            dp_q          <= 1'b1;
            frame_sync_q  <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            idx_q         <= idx_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            stage_val_q   <= stage_val_d;
            stage_dp_q    <= stage_dp_d;
            pending_q     <= pending_d;
            shadow_val_q  <= shadow_val_d;
            shadow_dp_q   <= shadow_dp_d;
            seg_q         <= seg_d;
            an_q          <= an_d;
            dp_q          <= dp_d;
            frame_sync_q  <= frame_sync_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign dp         = dp_q;
    assign frame_sync = frame_sync_q;

endmodule

// File: tb/tb_hex_display_mux.sv
// Bench for hex_display_mux: cycle-count based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_hex_display_mux;

    localparam int N  = 4;
    localparam int RD = 8;
    localparam int BC = 2;
    localparam int BF = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [4*N-1:0] value;
    logic [N-1:0]  dp_in;
    logic          load;
    logic [N-1:0]  digit_en;
    logic [N-1:0]  blink;
    logic          lz_blank;
    logic [6:0]    seg;
    logic [N-1:0]  an;
    logic          dp;
    logic          frame_sync;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hex_display_mux #(
        .NUM_DIGITS   (N),
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .value      (value),
        .dp_in      (dp_in),
        .load       (load),
        .digit_en   (digit_en),
        .blink      (blink),
        .lz_blank   (lz_blank),
        .seg        (seg),
        .an         (an),
        .dp         (dp),
        .frame_sync (frame_sync)
    );

    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: position in the scan follows directly from cycles since reset.
    int          t;
    int          m_presc, m_idx, m_frame, m_phase;
    bit          m_fend, m_dark;
    logic [15:0] m_shadow, m_stage;
    logic [3:0]  m_sdp, m_sdp_stage;
    logic [3:0]  m_nib;
    bit          m_pend;
    logic [6:0]  exp_seg;
    logic [3:0]  exp_an;
    logic        exp_dp, exp_fs;
    bit          check_en = 0;

    always @(posedge clk) begin
        if (rst) begin
            t = 0;
            m_shadow = '0; m_stage = '0; m_sdp = '0; m_sdp_stage = '0; m_pend = 0;
            exp_seg = 7'h7F; exp_an = 4'hF; exp_dp = 1'b1; exp_fs = 1'b0;
        end else begin
            m_presc = t % RD;
            m_idx   = (t / RD) % N;
            m_frame = t / (RD * N);
            m_phase = (m_frame / BF) % 2;
            m_fend  = (t % (RD * N)) == (RD * N - 1);
            m_nib   = 4'((m_shadow >> (4 * m_idx)) & 16'h000F);
            m_dark  = !digit_en[m_idx]
                   || (blink[m_idx] && m_phase == 1)
                   || (lz_blank && m_idx != 0 && (m_shadow >> (4 * m_idx)) == 16'h0);
            if (m_presc < BC || m_dark) begin
                exp_seg = 7'h7F; exp_an = 4'hF; exp_dp = 1'b1;
            end else begin
                exp_seg = glyph[m_nib];
                exp_an  = ~(4'b0001 << m_idx);
                exp_dp  = ~m_sdp[m_idx];
            end
            exp_fs = m_fend;
            if (load) begin
                m_stage = value; m_sdp_stage = dp_in; m_pend = 1;
            end
            if (m_fend && m_pend) begin
                m_shadow = m_stage; m_sdp = m_sdp_stage; m_pend = 0;
            end
            t++;
        end
        check_en = 1;
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("cyc_seg", 32'(seg), 32'(exp_seg));
            chk("cyc_an", 32'(an), 32'(exp_an));
            chk("cyc_dp", 32'(dp), 32'(exp_dp));
            chk("cyc_frame_sync", 32'(frame_sync), 32'(exp_fs));
            chk("cyc_an_onehot", 32'($countones(~an) <= 1), 32'd1);
        end
    end

    task automatic wait_fs();
        bit got = 0;
        for (int i = 0; i < 80 && !got; i++) begin
            @(negedge clk);
            if (frame_sync === 1'b1) got = 1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL wait_frame_sync: no pulse within 80 cycles");
        end
    endtask

    task automatic chk_out(input string name, input logic [3:0] e_an, input logic [6:0] e_seg,
                           input logic e_dp);
        chk({name, "_an"}, 32'(an), 32'(e_an));
        chk({name, "_seg"}, 32'(seg), 32'(e_seg));
        chk({name, "_dp"}, 32'(dp), 32'(e_dp));
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        value = v; dp_in = d; load = 1'b1;
        @(negedge clk);
        load = 1'b0; value = '0; dp_in = '0;
    endtask

    bit           s [8];
    int           lit_cnt;
    logic [3:0]   slot_an  [4];
    logic [6:0]   slot_seg [4];
    logic         slot_dp  [4];

    initial begin
        rst = 1'b1; value = '0; dp_in = '0; load = 1'b0;
        digit_en = 4'hF; blink = '0; lz_blank = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk_out("reset", 4'hF, 7'h7F, 1'b1);
        chk("reset_fs", 32'(frame_sync), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("guard_an", 32'(an), 32'hF);
        @(negedge clk);
        chk_out("first_lit", 4'b1110, 7'h40, 1'b1);

        // Load mid-frame: old value stays until the boundary
        do_load(16'h12AF, 4'b0100);
        repeat (8) @(negedge clk);
        chk_out("pre_sync", 4'b1101, 7'h40, 1'b1);
        wait_fs();
        slot_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        slot_seg = '{7'h0E, 7'h08, 7'h24, 7'h79};
        slot_dp  = '{1'b1, 1'b1, 1'b0, 1'b1};
        repeat (5) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) repeat (8) @(negedge clk);
            chk_out($sformatf("load_slot%0d", k), slot_an[k], slot_seg[k], slot_dp[k]);
        end

        // Leading-zero blanking
        lz_blank = 1'b1;
        do_load(16'h0005, 4'b0000);
        wait_fs();
        repeat (5) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) repeat (8) @(negedge clk);
            if (k == 0) chk_out("lz5_slot0", 4'b1110, 7'h12, 1'b1);
            else        chk_out($sformatf("lz5_slot%0d", k), 4'hF, 7'h7F, 1'b1);
        end
        do_load(16'h0000, 4'b0000);
        wait_fs();
        repeat (5) @(negedge clk);
        chk_out("lz0_slot0", 4'b1110, 7'h40, 1'b1);
        repeat (8) @(negedge clk);
        chk_out("lz0_slot1", 4'hF, 7'h7F, 1'b1);

        // Blink: digit 1 lit/dark in pairs of frames
        lz_blank = 1'b0;
        blink = 4'b0010;
        lit_cnt = 0;
        for (int f = 0; f < 8; f++) begin
            wait_fs();
            repeat (13) @(negedge clk);
            s[f] = (an == 4'b1101);
            if (s[f]) lit_cnt++;
        end
        chk("blink_lit_frames", 32'(lit_cnt), 32'd4);
        for (int i = 0; i < 4; i++) chk($sformatf("blink_period%0d", i), 32'(s[i]), 32'(s[i+4]));
        for (int i = 0; i < 6; i++) chk($sformatf("blink_half%0d", i), 32'(s[i] ^ s[i+2]), 32'd1);

        // Digit enable
        blink = '0;
        digit_en = 4'b1110;
        wait_fs();
        repeat (5) @(negedge clk);
        chk_out("en_slot0", 4'hF, 7'h7F, 1'b1);
        repeat (8) @(negedge clk);
        chk_out("en_slot1", 4'b1101, 7'h40, 1'b1);

        // Reset mid-operation discards a pending load
        digit_en = 4'hF;
        wait_fs();
        repeat (3) @(negedge clk);
        do_load(16'h9999, 4'hF);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_out("midrst", 4'hF, 7'h7F, 1'b1);
        chk("midrst_fs", 32'(frame_sync), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_out("post_rst", 4'b1110, 7'h40, 1'b1);
        wait_fs();
        repeat (5) @(negedge clk);
        chk_out("post_rst_frame", 4'b1110, 7'h40, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
